dsc_mul_seq: RTL and testbench
==============================

# dsc_mul_seq

Operand sequencer and result holder placed directly in front of `dsc_mul`, the 4-input, 10-bit deterministic stochastic multiplier. It accepts operand sets over a valid/ready handshake, clears and enables the multiplier, and waits for `ov`. It then captures the 40-bit product and the run length, and holds them for a downstream consumer. Operand sets containing a zero bypass the multiplier, and a cycle limit bounds how long any run can last.

## Interface
- `W`, 10: operand width. The product width is `4*W`.
- `CW`, 48: width of the run-length counter.
- `CLR_CYC`, 2: number of cycles `mul_rst` is held high before each run. Legal range is at least 1.
- `MAX_CYC`, 0: run timeout in cycles. A value of 0 disables the timeout.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: an operand set is offered.
- `in_ready` out 1: the block can accept an operand set.
- `in_a`, `in_b`, `in_c`, `in_d` in W each: the operands.
- `mul_rst` out 1: active-high clear to `dsc_mul.rst`.
- `mul_en` out 1: drives `dsc_mul.en`.
- `mul_a`, `mul_b`, `mul_c`, `mul_d` out W each: latched operands, driven to the `dsc_mul` operand inputs.
- `mul_z` in 4W: product from `dsc_mul.z`.
- `mul_ov` in 1: completion flag from `dsc_mul.ov`.
- `res_valid` out 1: a result is held.
- `res_ready` in 1: the consumer accepts the result.
- `res_z` out 4W: the product.
- `res_cycles` out CW: the number of RUN cycles the product took.
- `res_err` out 1: the run timed out.
- `busy` out 1: the state is not IDLE.

## Operation
- **States:** IDLE, CLEAR, RUN, DONE. Every output is registered except `busy`, which is decoded from the state.
- **Reset values:**
  - `in_ready`=0 and `res_valid`=0.
  - `mul_rst`=1 and `mul_en`=0.
  - `mul_a`..`mul_d`=0.
  - `res_z`=0, `res_cycles`=0, `res_err`=0.
  - State is IDLE.
- **IDLE:** `in_ready` rises at the first edge after `rst` deasserts. A transfer occurs at an edge where `in_valid` and `in_ready` are both 1. On a transfer:
  - The operands are latched into `mul_a`..`mul_d` and the cycle counter is cleared.
  - `in_ready` is cleared.
  - If any operand is 0, go to DONE with `res_z`=0, `res_cycles`=0, `res_err`=0. The multiplier is never enabled for that set.
  - Otherwise go to CLEAR.
- **CLEAR:** hold `mul_rst`=1 and `mul_en`=0 for exactly `CLR_CYC` cycles, then go to RUN.
- **RUN:**
  - `mul_rst`=0 and `mul_en`=1.
  - The counter increments on every RUN edge and saturates at all-ones.
  - When `mul_ov` is sampled 1, capture `res_z`=`mul_z` and `res_cycles`=count including that edge, set `res_err`=0, and go to DONE.
  - If `MAX_CYC`≠0 and the count reaches `MAX_CYC` without `ov`, go to DONE with `res_z`=0, `res_cycles`=`MAX_CYC`, `res_err`=1.
  - If `ov` and the limit occur on the same edge, `ov` wins.
- **DONE:**
  - `res_valid`=1, `mul_en`=0, `mul_rst`=1.
  - `res_*` stay stable until `res_ready` is sampled 1.
  - On that edge, `res_valid` goes to 0, `in_ready` goes to 1, and the state returns to IDLE.
- **Ignored inputs:** `mul_ov` is ignored outside RUN. `in_valid` is ignored while `in_ready`=0.
- **Reset mid-operation:** an asserted `rst` immediately forces every reset value, including `mul_rst`=1. Any in-flight set is discarded and no result is produced for it.

## Timing
- **Accept to start:** accepting at edge N makes `mul_rst`=1 from edge N. `mul_en` rises at edge N+`CLR_CYC`.
- **Completion:** if `ov` is sampled at edge M, `res_valid`, `mul_en`=0 and `mul_rst`=1 all take effect from edge M.
- **Zero bypass:** accepting at edge N gives `res_valid`=1 from edge N.
- **Result release:** `res_ready` sampled at edge R clears `res_valid` from edge R and sets `in_ready` from edge R. The next transfer can happen no earlier than edge R+1.
- **Operand stability:** `mul_a`..`mul_d` are stable from acceptance until the next acceptance.

## Test plan
- **Reset values:** hold `rst` low for 3 cycles. All outputs must sit at their reset values. `in_ready` must be 1 exactly one edge after release.
- **Normal run (behavioural `dsc_mul` model, `ov` after L=37 enabled cycles, `z`=a·b·c·d):**
  - Stimulus: a=b=c=d=15, `CLR_CYC`=2.
  - Required: `mul_en` rises 2 edges after accept, `res_z`=50625, `res_cycles`=37, `res_err`=0.
- **Zero bypass:** a=0, b=700, c=3, d=9. Required: `res_valid` from the accept edge, `res_z`=0, `res_cycles`=0, `mul_en` never 1.
- **Backpressure:** hold `res_ready`=0 for 10 cycles after `res_valid` while `in_valid`=1 with new operands. Required: `res_*` stay constant, `in_ready`=0, and the new set transfers only after `res_ready`=1.
- **Timeout:** `MAX_CYC`=16 with `mul_ov` tied to 0. Required: `res_err`=1 and `res_cycles`=16 after 16 RUN cycles. Repeat with `ov` arriving on cycle 16: required `res_err`=0.
- **Reset mid-RUN:** pull `rst` low mid-RUN. Required: `mul_rst`=1 and `mul_en`=0 without waiting for a clock edge, and no `res_valid`. A following set a=1, b=2, c=3, d=4 must return `res_z`=24.

Source files
------------

// File: rtl/dsc_mul_seq.sv
// Operand sequencer and result holder for the dsc_mul stochastic multiplier.
// Handles the clear/run sequencing, zero bypass, the optional timeout and result holding.
module dsc_mul_seq #(
  parameter int W       = 10,
  parameter int CW      = 48,
  parameter int CLR_CYC = 2,
  parameter int MAX_CYC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic [W-1:0]    in_c,
  input  logic [W-1:0]    in_d,
  output logic            mul_rst,
  output logic            mul_en,
  output logic [W-1:0]    mul_a,
  output logic [W-1:0]    mul_b,
  output logic [W-1:0]    mul_c,
  output logic [W-1:0]    mul_d,
  input  logic [4*W-1:0]  mul_z,
  input  logic            mul_ov,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [4*W-1:0]  res_z,
  output logic [CW-1:0]   res_cycles,
  output logic            res_err,
  output logic            busy
);

  localparam int CLRW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t state_reg, state_next;

  logic [CLRW-1:0] clr_cnt_reg, clr_cnt_next;
  logic [CW-1:0]   cnt_reg, cnt_next, cnt_inc;
  logic            in_ready_next, res_valid_next, mul_rst_next, mul_en_next, res_err_next;
  logic [W-1:0]    a_next, b_next, c_next, d_next;
  logic [4*W-1:0]  res_z_next;
  logic [CW-1:0]   res_cycles_next;

  logic take, any_zero, clr_last, timeout;

  assign take     = (state_reg == IDLE) && in_valid && in_ready;
  assign any_zero = (in_a == '0) || (in_b == '0) || (in_c == '0) || (in_d == '0);
  assign clr_last = (clr_cnt_reg == CLRW'(CLR_CYC - 1));
  // Run-length counter saturates rather than wrapping.
  assign cnt_inc  = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
  assign timeout  = (MAX_CYC != 0) && (cnt_inc == CW'(MAX_CYC));
  assign busy     = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      clr_cnt_reg <= '0;
      cnt_reg     <= '0;
      in_ready    <= 1'b0;
      res_valid   <= 1'b0;
      mul_rst     <= 1'b1;
      mul_en      <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_c       <= '0;
      mul_d       <= '0;
      res_z       <= '0;
      res_cycles  <= '0;
      res_err     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
      cnt_reg     <= cnt_next;
      in_ready    <= in_ready_next;
      res_valid   <= res_valid_next;
      mul_rst     <= mul_rst_next;
      mul_en      <= mul_en_next;
      mul_a       <= a_next;
      mul_b       <= b_next;
      mul_c       <= c_next;
      mul_d       <= d_next;
      res_z       <= res_z_next;
      res_cycles  <= res_cycles_next;
      res_err     <= res_err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (take) state_next = any_zero ? DONE : CLEAR;
      CLEAR:   if (clr_last) state_next = RUN;
      RUN:     if (mul_ov || timeout) state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready_next   = in_ready;
    res_valid_next  = res_valid;
    mul_rst_next    = mul_rst;
    mul_en_next     = mul_en;
    a_next          = mul_a;
    b_next          = mul_b;
    c_next          = mul_c;
    d_next          = mul_d;
    res_z_next      = res_z;
    res_cycles_next = res_cycles;
    res_err_next    = res_err;
    clr_cnt_next    = clr_cnt_reg;
    cnt_next        = cnt_reg;
    case (state_reg)
      IDLE: begin
        in_ready_next = 1'b1;
        mul_rst_next  = 1'b1;
        mul_en_next   = 1'b0;
        if (take) begin
          in_ready_next = 1'b0;
          a_next        = in_a;
          b_next        = in_b;
          c_next        = in_c;
          d_next        = in_d;
          cnt_next      = '0;
          clr_cnt_next  = '0;
          if (any_zero) begin
            res_valid_next  = 1'b1;
            res_z_next      = '0;
            res_cycles_next = '0;
            res_err_next    = 1'b0;
          end
        end
      end
      CLEAR: begin
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_last) begin
          mul_rst_next = 1'b0;
          mul_en_next  = 1'b1;
        end
      end
      RUN: begin
        cnt_next = cnt_inc;
        // A completion on the limit edge is reported as a normal result.
        if (mul_ov) begin
          res_valid_next  = 1'b1;
          res_z_next      = mul_z;
          res_cycles_next = cnt_inc;
          res_err_next    = 1'b0;
          mul_en_next     = 1'b0;
          mul_rst_next    = 1'b1;
        end else if (timeout) begin
          res_valid_next  = 1'b1;
          res_z_next      = '0;
          res_cycles_next = CW'(MAX_CYC);
          res_err_next    = 1'b1;
          mul_en_next     = 1'b0;
          mul_rst_next    = 1'b1;
        end
      end
      DONE: begin
        mul_en_next  = 1'b0;
        mul_rst_next = 1'b1;
        if (res_ready) begin
          res_valid_next = 1'b0;
          in_ready_next  = 1'b1;
        end
      end
      default: begin
        mul_en_next  = 1'b0;
        mul_rst_next = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Bench for dsc_mul_seq: two instances (no timeout / 16-cycle timeout), each driving an
// emulated dsc_mul, checked every cycle against a timeline model of each accepted set.
module tb_dsc_mul_seq;
  localparam int W   = 10;
  localparam int CW  = 48;
  localparam int CLR = 2;
  localparam int ZW  = 4 * W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid [2];
  logic          in_ready [2];
  logic [W-1:0]  in_a [2], in_b [2], in_c [2], in_d [2];
  logic          mul_rst [2], mul_en [2], mul_ov [2];
  logic [W-1:0]  mul_a [2], mul_b [2], mul_c [2], mul_d [2];
  logic [ZW-1:0] mul_z [2], res_z [2];
  logic          res_valid [2], res_ready [2], res_err [2], busy [2];
  logic [CW-1:0] res_cycles [2];

  int l_len [2];
  bit ov_off [2];

  int n_total = 0;
  int n_pass  = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    int k = 0;

    dsc_mul_seq #(.W(W), .CW(CW), .CLR_CYC(CLR), .MAX_CYC(gi * 16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[gi]), .in_ready(in_ready[gi]),
      .in_a(in_a[gi]), .in_b(in_b[gi]), .in_c(in_c[gi]), .in_d(in_d[gi]),
      .mul_rst(mul_rst[gi]), .mul_en(mul_en[gi]),
      .mul_a(mul_a[gi]), .mul_b(mul_b[gi]), .mul_c(mul_c[gi]), .mul_d(mul_d[gi]),
      .mul_z(mul_z[gi]), .mul_ov(mul_ov[gi]),
      .res_valid(res_valid[gi]), .res_ready(res_ready[gi]),
      .res_z(res_z[gi]), .res_cycles(res_cycles[gi]), .res_err(res_err[gi]),
      .busy(busy[gi])
    );

    // Emulated multiplier: ov on the l_len-th enabled edge, z = a*b*c*d.
    always_ff @(posedge clk) begin
      if (mul_rst[gi]) k <= 0;
      else if (mul_en[gi]) k <= k + 1;
    end
    assign mul_ov[gi] = mul_en[gi] && !ov_off[gi] && (k >= l_len[gi] - 1);
    assign mul_z[gi]  = ZW'(mul_a[gi]) * ZW'(mul_b[gi]) * ZW'(mul_c[gi]) * ZW'(mul_d[gi]);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Timeline model: per accepted set, the edge numbers where run starts and result appears.
  int     m_t;
  bit     m_started [2], m_ready [2], m_active [2];
  int     m_en_from [2], m_done [2];
  longint m_res_z [2], m_res_c [2], m_prev_z [2], m_prev_c [2];
  bit     m_res_e [2], m_prev_e [2];
  int     m_ops [2][4];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_started[i] = 0; m_ready[i] = 0; m_active[i] = 0;
      m_en_from[i] = 0; m_done[i] = 0;
      m_res_z[i] = 0; m_res_c[i] = 0; m_res_e[i] = 0;
      m_prev_z[i] = 0; m_prev_c[i] = 0; m_prev_e[i] = 0;
      for (int j = 0; j < 4; j++) m_ops[i][j] = 0;
    end
  endtask

  initial begin
    m_t = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else begin
        m_t++;
        for (int i = 0; i < 2; i++) begin
          if (!m_started[i]) begin
            m_started[i] = 1;
            m_ready[i]   = 1;
          end else if (m_active[i]) begin
            if (m_t > m_done[i] && res_ready[i]) begin
              m_active[i] = 0; m_ready[i] = 1;
              m_prev_z[i] = m_res_z[i]; m_prev_c[i] = m_res_c[i]; m_prev_e[i] = m_res_e[i];
            end
          end else if (m_ready[i] && in_valid[i]) begin
            int mx, run;
            bit to;
            m_ops[i][0] = int'(in_a[i]); m_ops[i][1] = int'(in_b[i]);
            m_ops[i][2] = int'(in_c[i]); m_ops[i][3] = int'(in_d[i]);
            m_active[i] = 1; m_ready[i] = 0;
            if (m_ops[i][0] == 0 || m_ops[i][1] == 0 || m_ops[i][2] == 0 || m_ops[i][3] == 0) begin
              m_done[i] = m_t; m_en_from[i] = m_t;
              m_res_z[i] = 0; m_res_c[i] = 0; m_res_e[i] = 0;
            end else begin
              mx  = i * 16;
              to  = ov_off[i] || (mx != 0 && l_len[i] > mx);
              run = to ? mx : l_len[i];
              m_en_from[i] = m_t + CLR;
              m_done[i]    = m_t + CLR + run;
              m_res_e[i]   = to;
              m_res_c[i]   = run;
              m_res_z[i]   = to ? 0 : longint'(m_ops[i][0]) * m_ops[i][1] * m_ops[i][2] * m_ops[i][3];
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        bit v, e;
        v = m_active[i] && (m_t >= m_done[i]);
        e = m_active[i] && (m_t >= m_en_from[i]) && (m_t < m_done[i]);
        chk($sformatf("dut%0d in_ready t=%0t", i, $time), in_ready[i], m_ready[i]);
        chk($sformatf("dut%0d busy t=%0t", i, $time), busy[i], m_active[i]);
        chk($sformatf("dut%0d mul_en t=%0t", i, $time), mul_en[i], e);
        chk($sformatf("dut%0d mul_rst t=%0t", i, $time), mul_rst[i], !e);
        chk($sformatf("dut%0d res_valid t=%0t", i, $time), res_valid[i], v);
        chk($sformatf("dut%0d res_z t=%0t", i, $time), res_z[i], v ? m_res_z[i] : m_prev_z[i]);
        chk($sformatf("dut%0d res_cycles t=%0t", i, $time), res_cycles[i], v ? m_res_c[i] : m_prev_c[i]);
        chk($sformatf("dut%0d res_err t=%0t", i, $time), res_err[i], v ? m_res_e[i] : m_prev_e[i]);
        chk($sformatf("dut%0d mul_a t=%0t", i, $time), mul_a[i], m_ops[i][0]);
        chk($sformatf("dut%0d mul_b t=%0t", i, $time), mul_b[i], m_ops[i][1]);
        chk($sformatf("dut%0d mul_c t=%0t", i, $time), mul_c[i], m_ops[i][2]);
        chk($sformatf("dut%0d mul_d t=%0t", i, $time), mul_d[i], m_ops[i][3]);
      end
    end
  end

  int bp_a, bp_b, bp_c, bp_d, bp_len;

  task automatic xact(input int i, input int a, input int b, input int c, input int d,
                      input int len, input bit off, input int hold, input bit bp, input bit pre,
                      output longint z, output longint cyc, output bit err,
                      output int en_dly, output int v_dly);
    int n;
    z = -1; cyc = -1; err = 0; en_dly = -1; v_dly = -1;
    if (!pre) begin
      @(negedge clk);
      in_a[i] = W'(a); in_b[i] = W'(b); in_c[i] = W'(c); in_d[i] = W'(d);
      l_len[i] = len; ov_off[i] = off; in_valid[i] = 1'b1;
    end
    n = 0;
    while (!in_ready[i] && n < 200) begin @(negedge clk); n++; end
    if (!in_ready[i]) begin
      chk($sformatf("dut%0d accept wait", i), 0, 1);
      in_valid[i] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid[i] = 1'b0;
    n = 1;
    while (!res_valid[i] && n < 600) begin
      if (mul_en[i] && en_dly < 0) en_dly = n - 1;
      @(negedge clk);
      n++;
    end
    if (!res_valid[i]) chk($sformatf("dut%0d result wait", i), res_valid[i], 1);
    v_dly = n - 1;
    z = longint'(res_z[i]); cyc = longint'(res_cycles[i]); err = res_err[i];
    for (int h = 0; h < hold; h++) begin
      if (bp) begin
        in_a[i] = W'(bp_a); in_b[i] = W'(bp_b); in_c[i] = W'(bp_c); in_d[i] = W'(bp_d);
        l_len[i] = bp_len; ov_off[i] = 0; in_valid[i] = 1'b1;
      end
      @(negedge clk);
    end
    res_ready[i] = 1'b1;
    @(negedge clk);
    res_ready[i] = 1'b0;
  endtask

  initial begin
    longint z, cyc;
    bit     err;
    int     ed, vd, sel, len;
    int     op [4];
    bit     off;

    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 0; res_ready[i] = 0;
      in_a[i] = '0; in_b[i] = '0; in_c[i] = '0; in_d[i] = '0;
      l_len[i] = 1; ov_off[i] = 0;
    end

    repeat (3) @(negedge clk);
    chk("reset in_ready dut0", in_ready[0], 0);
    chk("reset mul_rst dut0", mul_rst[0], 1);
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready one edge after release dut0", in_ready[0], 1);
    chk("in_ready one edge after release dut1", in_ready[1], 1);

    xact(0, 15, 15, 15, 15, 37, 0, 0, 0, 0, z, cyc, err, ed, vd);
    $display("normal run: z=%0d cycles=%0d err=%0d en_delay=%0d", z, cyc, err, ed);
    chk("normal res_z", z, 50625);
    chk("normal res_cycles", cyc, 37);
    chk("normal res_err", err, 0);
    chk("normal mul_en delay", ed, 2);

    xact(0, 0, 700, 3, 9, 5, 0, 2, 0, 0, z, cyc, err, ed, vd);
    $display("zero bypass: z=%0d cycles=%0d valid_delay=%0d", z, cyc, vd);
    chk("bypass res_z", z, 0);
    chk("bypass res_cycles", cyc, 0);
    chk("bypass valid delay", vd, 0);
    chk("bypass mul_en seen", ed, -1);

    bp_a = 3; bp_b = 4; bp_c = 5; bp_d = 6; bp_len = 9;
    xact(0, 7, 8, 9, 10, 5, 0, 10, 1, 0, z, cyc, err, ed, vd);
    $display("backpressure first: z=%0d cycles=%0d", z, cyc);
    chk("backpressure first res_z", z, 5040);
    chk("backpressure first res_cycles", cyc, 5);
    xact(0, 3, 4, 5, 6, 9, 0, 0, 0, 1, z, cyc, err, ed, vd);
    $display("backpressure held set: z=%0d cycles=%0d", z, cyc);
    chk("backpressure held res_z", z, 360);
    chk("backpressure held res_cycles", cyc, 9);

    xact(1, 11, 12, 13, 14, 1, 1, 1, 0, 0, z, cyc, err, ed, vd);
    $display("timeout: z=%0d cycles=%0d err=%0d", z, cyc, err);
    chk("timeout res_err", err, 1);
    chk("timeout res_cycles", cyc, 16);
    chk("timeout res_z", z, 0);
    xact(1, 2, 3, 5, 7, 16, 0, 0, 0, 0, z, cyc, err, ed, vd);
    $display("ov on limit: z=%0d cycles=%0d err=%0d", z, cyc, err);
    chk("ov on limit res_err", err, 0);
    chk("ov on limit res_cycles", cyc, 16);
    chk("ov on limit res_z", z, 210);

    @(negedge clk);
    in_a[0] = 5; in_b[0] = 6; in_c[0] = 7; in_d[0] = 8;
    l_len[0] = 37; ov_off[0] = 0; in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid-run mul_en before reset", mul_en[0], 1);
    #2 rst = 1'b0;
    #1;
    $display("mid-run reset: mul_rst=%0d mul_en=%0d res_valid=%0d", mul_rst[0], mul_en[0], res_valid[0]);
    chk("mid-run reset mul_rst", mul_rst[0], 1);
    chk("mid-run reset mul_en", mul_en[0], 0);
    chk("mid-run reset res_valid", res_valid[0], 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    xact(0, 1, 2, 3, 4, 12, 0, 0, 0, 0, z, cyc, err, ed, vd);
    $display("after reset: z=%0d cycles=%0d", z, cyc);
    chk("after reset res_z", z, 24);

    for (int r = 0; r < 40; r++) begin
      sel = int'($urandom_range(0, 1));
      for (int j = 0; j < 4; j++)
        op[j] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 1023));
      len = int'($urandom_range(1, 40));
      off = (sel == 1) && ($urandom_range(0, 5) == 0);
      xact(sel, op[0], op[1], op[2], op[3], len, off, int'($urandom_range(0, 3)), 0, 0,
           z, cyc, err, ed, vd);
      $display("rand %0d dut%0d ops=%0d,%0d,%0d,%0d L=%0d off=%0d -> z=%0d cycles=%0d err=%0d",
               r, sel, op[0], op[1], op[2], op[3], len, off, z, cyc, err);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
